id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
Instruction-decode stage directly upstream of the ALU in the 32-bit MIPS pipeline. It takes a fetched instruction and PC, reads the 32x32 register file, and decodes fields and control. It also detects load-use hazards and registers everything into the ID/EX pipeline register that feeds the ALU's opcode, SRC, TARG, immediate, funct, shamt and pc inputs. It also owns the register-file write port used by writeback.

Parameters:
NREGS, 32, number of architectural registers (register 0 hard-wired to zero)
XLEN, 32, datapath width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  fetch presents a valid instruction
in_instr  in  32  instruction word
in_pc  in  32  PC of in_instr
flush  in  1  branch/jump taken: discard the instruction in decode
wb_en  in  1  writeback enable
wb_addr  in  5  writeback register index
wb_data  in  32  writeback data
stall  out  1  combinational: fetch must hold in_instr/in_pc this cycle
out_valid  out  1  ID/EX entry valid
out_opcode  out  6  instr[31:26]
out_funct  out  6  instr[5:0]
out_shamt  out  5  instr[10:6]
out_src  out  32  rs value
out_targ  out  32  rt value
out_imm  out  32  extended immediate
out_pc  out  32  registered in_pc
out_dest  out  5  destination register
out_reg_write  out  1  result written back
out_mem_read  out  1  LW
out_mem_write  out  1  SW
out_illegal  out  1  unsupported opcode/funct

Behaviour:
- Reset (async, rst=1): all ID/EX outputs 0; all registers 0. stall is 0 while in reset.
- Register file: 2 combinational read ports and 1 synchronous write port. Writes to r0 are ignored. A read of r0 returns 0.
- Write-first bypass: if wb_en and wb_addr equals a read index (nonzero), that read returns wb_data in the same cycle.
- Supported opcodes:
  - R-type 000000 with funct add 100000, sub 100010, and 100100, or 100101, xor 100110, slt 101010, sll 000000, srl 000010: dest=rd, reg_write=1.
  - addi 001000: dest=rt, reg_write=1, sign-extended imm.
  - andi 001100: dest=rt, reg_write=1, zero-extended imm.
  - lw 100011: dest=rt, reg_write=1, mem_read=1, sign-extended imm.
  - sw 101011: mem_write=1, sign-extended imm.
  - beq 000100 and bne 000101: sign-extended imm.
  - j 000010: out_imm = zero-extended instr[25:0].
- For sw, beq, bne and j: dest=0, reg_write=0.
- Any other opcode or R-type funct: out_illegal=1 and all control bits 0. out_valid still follows the rules below.
- rt usage: rt counts as a source operand for R-type, sw, beq and bne only.
- Load-use hazard: stall=1 when all of the following hold:
  - in_valid, flush=0
  - out_valid, out_mem_read, out_dest!=0
  - out_dest equals in_instr rs, or equals rt where rt is used as a source
- Update priority at each rising edge (first match wins):
  1. flush=1: out_valid<=0 and other outputs hold; stall forced 0.
  2. stall=1: insert bubble, out_valid<=0 and all control bits <=0. The same instruction is re-decoded next cycle, because fetch holds it.
  3. Otherwise: ID/EX <= decode of in_instr; out_valid<=in_valid. Control bits are gated by in_valid.
- Latency: 1 cycle from instruction accepted to out_* valid. A load-use adds exactly 1 bubble.
- A writeback to the hazard register in the stalled cycle is captured by the bypass on re-decode.
- Reset asserted mid-stall clears the pipeline register immediately; no instruction is replayed by this block.

Decomposition:
- Shared package mips_pkg: opcode constants (OP_RTYPE, OP_ADDI, OP_ANDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J) and funct constants (F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_SLT, F_SLL, F_SRL). The ALU consumes the same package.
- One sub-module: reg_file (2R1W, r0=0, write-first bypass). Decode, hazard and pipeline register stay in id_stage.

Test Plan:
- Reset: rst=1 then 0 → all out_* = 0, stall=0. Reading r5 afterwards gives 0.
- Writeback then R-type:
  - Stimulus: wb r1=5, wb r2=3, then add r3,r1,r2 (0x00221820) at pc 0x40.
  - Next cycle: out_src=5, out_targ=3, out_dest=3, out_reg_write=1, out_pc=0x40.
- Bypass and r0:
  - wb_en r4=0x1234 in the same cycle as addi r5,r4,-1 → out_src=0x1234, out_imm=0xFFFFFFFF.
  - wb to r0 → a later read of r0 gives 0.
- andi zero-extend: andi r6,r1,0x8000 → out_imm=0x00008000.
- Load-use:
  - Stimulus: lw r2,4(r1) followed by add r3,r2,r1.
  - Required: stall=1 for exactly 1 cycle and a bubble (out_valid=0); add issues the following cycle.
  - Negative case: lw r2 followed by sw r7,0(r1) → no stall.
- Flush and illegal:
  - flush=1 together with a valid stalled instruction → out_valid=0, stall=0.
  - Opcode 111111 → out_illegal=1, control bits 0.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - MIPS opcode and funct encodings shared by decode and ALU
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_XOR = 6'b100110;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_SLL = 6'b000000;
    localparam logic [5:0] F_SRL = 6'b000010;

endpackage

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 2-read 1-write register file, r0 reads zero, write-first bypass
module reg_file #(
    parameter int NREGS = 32,
    parameter int XLEN  = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   ra1_i,
    input  logic [AW-1:0]   ra2_i,
    output logic [XLEN-1:0] rd1_o,
    output logic [XLEN-1:0] rd2_o,
    input  logic            we_i,
    input  logic [AW-1:0]   wa_i,
    input  logic [XLEN-1:0] wd_i
);

    logic [XLEN-1:0] regs_q [NREGS];

    // Storage: cleared on reset, writes to r0 dropped so it stays zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (wa_i != '0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    // Read ports: a same-cycle writeback to the read index wins over storage
    always_comb begin
        rd1_o = regs_q[ra1_i];
        rd2_o = regs_q[ra2_i];
        if (ra1_i == '0) begin
            rd1_o = '0;
        end else if (we_i && (wa_i == ra1_i)) begin
            rd1_o = wd_i;
        end
        if (ra2_i == '0) begin
            rd2_o = '0;
        end else if (we_i && (wa_i == ra2_i)) begin
            rd2_o = wd_i;
        end
    end

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - MIPS decode stage: regfile read, control decode, load-use stall, ID/EX register
module id_stage
    import mips_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            stall,
    output logic            out_valid,
    output logic [5:0]      out_opcode,
    output logic [5:0]      out_funct,
    output logic [4:0]      out_shamt,
    output logic [XLEN-1:0] out_src,
    output logic [XLEN-1:0] out_targ,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_dest,
    output logic            out_reg_write,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic            out_illegal
);

    logic [5:0]      opcode;
    logic [5:0]      funct;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] rt_val;

    assign opcode = in_instr[31:26];
    assign rs     = in_instr[25:21];
    assign rt     = in_instr[20:16];
    assign rd     = in_instr[15:11];
    assign funct  = in_instr[5:0];

    reg_file #(
        .NREGS (NREGS),
        .XLEN  (XLEN)
    ) u_reg_file (
        .clk   (clk),
        .rst   (rst),
        .ra1_i (rs),
        .ra2_i (rt),
        .rd1_o (rs_val),
        .rd2_o (rt_val),
        .we_i  (wb_en),
        .wa_i  (wb_addr),
        .wd_i  (wb_data)
    );

    logic [4:0]      dec_dest;
    logic            dec_rw;
    logic            dec_mr;
    logic            dec_mw;
    logic            dec_ill;
    logic            dec_rt_used;
    logic [XLEN-1:0] dec_imm;

    // Control decode; illegal encodings leave every control bit clear
    always_comb begin
        dec_dest    = '0;
        dec_rw      = 1'b0;
        dec_mr      = 1'b0;
        dec_mw      = 1'b0;
        dec_ill     = 1'b0;
        dec_rt_used = 1'b0;
        dec_imm     = {{(XLEN-16){in_instr[15]}}, in_instr[15:0]};
        unique case (opcode)
            OP_RTYPE: begin
                dec_rt_used = 1'b1;
                unique case (funct)
                    F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_SLT, F_SLL, F_SRL: begin
                        dec_dest = rd;
                        dec_rw   = 1'b1;
                    end
                    default: dec_ill = 1'b1;
                endcase
            end
            OP_ADDI: begin
                dec_dest = rt;
                dec_rw   = 1'b1;
            end
            OP_ANDI: begin
                dec_dest = rt;
                dec_rw   = 1'b1;
                dec_imm  = {{(XLEN-16){1'b0}}, in_instr[15:0]};
            end
            OP_LW: begin
                dec_dest = rt;
                dec_rw   = 1'b1;
                dec_mr   = 1'b1;
            end
            OP_SW: begin
                dec_mw      = 1'b1;
                dec_rt_used = 1'b1;
            end
            OP_BEQ, OP_BNE: dec_rt_used = 1'b1;
            OP_J:    dec_imm = {{(XLEN-26){1'b0}}, in_instr[25:0]};
            default: dec_ill = 1'b1;
        endcase
    end

    // Load-use: the load in ID/EX produces a register this instruction reads
    assign stall = !rst && in_valid && !flush &&
                   out_valid && out_mem_read && (out_dest != '0) &&
                   ((out_dest == rs) || (dec_rt_used && (out_dest == rt)));

    // ID/EX register: flush drops the entry, stall inserts a bubble, else capture decode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid     <= 1'b0;
            out_opcode    <= '0;
            out_funct     <= '0;
            out_shamt     <= '0;
            out_src       <= '0;
            out_targ      <= '0;
            out_imm       <= '0;
            out_pc        <= '0;
            out_dest      <= '0;
            out_reg_write <= 1'b0;
            out_mem_read  <= 1'b0;
            out_mem_write <= 1'b0;
            out_illegal   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (stall) begin
            out_valid     <= 1'b0;
            out_dest      <= '0;
            out_reg_write <= 1'b0;
            out_mem_read  <= 1'b0;
            out_mem_write <= 1'b0;
            out_illegal   <= 1'b0;
        end else begin
            out_valid     <= in_valid;
            out_opcode    <= opcode;
            out_funct     <= funct;
            out_shamt     <= in_instr[10:6];
            out_src       <= rs_val;
            out_targ      <= rt_val;
            out_imm       <= dec_imm;
            out_pc        <= in_pc;
            out_dest      <= in_valid ? dec_dest : 5'd0;
            out_reg_write <= in_valid && dec_rw;
            out_mem_read  <= in_valid && dec_mr;
            out_mem_write <= in_valid && dec_mw;
            out_illegal   <= in_valid && dec_ill;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - scoreboard bench for id_stage
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        stall;
    logic        out_valid;
    logic [5:0]  out_opcode;
    logic [5:0]  out_funct;
    logic [4:0]  out_shamt;
    logic [31:0] out_src;
    logic [31:0] out_targ;
    logic [31:0] out_imm;
    logic [31:0] out_pc;
    logic [4:0]  out_dest;
    logic        out_reg_write;
    logic        out_mem_read;
    logic        out_mem_write;
    logic        out_illegal;

    id_stage dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .flush         (flush),
        .wb_en         (wb_en),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .stall         (stall),
        .out_valid     (out_valid),
        .out_opcode    (out_opcode),
        .out_funct     (out_funct),
        .out_shamt     (out_shamt),
        .out_src       (out_src),
        .out_targ      (out_targ),
        .out_imm       (out_imm),
        .out_pc        (out_pc),
        .out_dest      (out_dest),
        .out_reg_write (out_reg_write),
        .out_mem_read  (out_mem_read),
        .out_mem_write (out_mem_write),
        .out_illegal   (out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          stall;
        bit          valid;
        bit          chk_ctl;
        bit          chk_data;
        bit          chk_imm;
        logic [5:0]  op;
        logic [4:0]  dest;
        bit          rw;
        bit          mr;
        bit          mw;
        bit          ill;
        logic [31:0] src;
        logic [31:0] targ;
        logic [31:0] imm;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t ev(input logic [5:0] op, input logic [4:0] dest,
                                input bit rw, input bit mr, input bit mw, input bit ill,
                                input logic [31:0] src, input logic [31:0] targ,
                                input logic [31:0] imm, input bit chk_imm, input logic [31:0] pc);
        exp_t e;
        e.stall = 1'b0; e.valid = 1'b1; e.chk_ctl = 1'b1; e.chk_data = 1'b1; e.chk_imm = chk_imm;
        e.op = op; e.dest = dest; e.rw = rw; e.mr = mr; e.mw = mw; e.ill = ill;
        e.src = src; e.targ = targ; e.imm = imm; e.pc = pc;
        return e;
    endfunction

    // No valid entry; control bits checked unless chk_ctl is cleared (flush holds them)
    function automatic exp_t enone(input bit stl, input bit chk_ctl);
        exp_t e;
        e = ev(6'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
        e.stall = stl; e.valid = 1'b0; e.chk_ctl = chk_ctl; e.chk_data = 1'b0;
        return e;
    endfunction

    task automatic cycle(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                         input logic fl, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input exp_t e);
        exp_t x;
        @(negedge clk);
        in_valid = v; in_instr = instr; in_pc = pc; flush = fl;
        wb_en = we; wb_addr = wa; wb_data = wd;
        #1;
        check("stall", 32'(stall), 32'(e.stall));
        sb.push_back(e);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check("out_valid", 32'(out_valid), 32'(x.valid));
        if (x.chk_ctl) begin
            check("out_reg_write", 32'(out_reg_write), 32'(x.rw));
            check("out_mem_read", 32'(out_mem_read), 32'(x.mr));
            check("out_mem_write", 32'(out_mem_write), 32'(x.mw));
            check("out_illegal", 32'(out_illegal), 32'(x.ill));
            if (x.valid) check("out_dest", 32'(out_dest), 32'(x.dest));
        end
        if (x.chk_data) begin
            check("out_opcode", 32'(out_opcode), 32'(x.op));
            check("out_src", out_src, x.src);
            check("out_targ", out_targ, x.targ);
            check("out_pc", out_pc, x.pc);
            if (x.chk_imm) check("out_imm", out_imm, x.imm);
        end
    endtask

    localparam logic [31:0] ADD_9_5_5  = 32'h00A54820;
    localparam logic [31:0] ADD_3_1_2  = 32'h00221820;
    localparam logic [31:0] ADDI_5_4   = 32'h2085FFFF;
    localparam logic [31:0] ANDI_6_1   = 32'h30268000;
    localparam logic [31:0] ADD_8_0_0  = 32'h00004020;
    localparam logic [31:0] LW_2_1     = 32'h8C220004;
    localparam logic [31:0] ADD_3_2_1  = 32'h00411820;
    localparam logic [31:0] SW_7_1     = 32'hAC270000;
    localparam logic [31:0] ILLEGAL    = 32'hFC000000;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ctl", 32'({out_reg_write, out_mem_read, out_mem_write, out_illegal}), 32'd0);
        check("rst_dest", 32'(out_dest), 32'd0);
        check("rst_src", out_src, 32'd0);
        check("rst_pc", out_pc, 32'd0);
        check("rst_stall", 32'(stall), 32'd0);

        cycle(1, ADD_9_5_5, 32'h10, 0, 0, 5'd0, 32'h0,
              ev(6'h00, 5'd9, 1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 32'h10));
        cycle(0, 32'h0, 32'h0, 0, 1, 5'd1, 32'd5, enone(0, 1));
        cycle(0, 32'h0, 32'h0, 0, 1, 5'd2, 32'd3, enone(0, 1));
        cycle(1, ADD_3_1_2, 32'h40, 0, 0, 5'd0, 32'h0,
              ev(6'h00, 5'd3, 1, 0, 0, 0, 32'd5, 32'd3, 32'h0, 0, 32'h40));
        cycle(1, ADDI_5_4, 32'h44, 0, 1, 5'd4, 32'h1234,
              ev(6'h08, 5'd5, 1, 0, 0, 0, 32'h1234, 32'h0, 32'hFFFFFFFF, 1, 32'h44));
        cycle(1, ANDI_6_1, 32'h48, 0, 0, 5'd0, 32'h0,
              ev(6'h0C, 5'd6, 1, 0, 0, 0, 32'd5, 32'h0, 32'h00008000, 1, 32'h48));
        cycle(1, ADD_8_0_0, 32'h4C, 0, 1, 5'd0, 32'hDEAD,
              ev(6'h00, 5'd8, 1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 32'h4C));
        cycle(1, ADD_8_0_0, 32'h50, 0, 0, 5'd0, 32'h0,
              ev(6'h00, 5'd8, 1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 32'h50));
        // load-use: one bubble, and the writeback during the stall reaches the re-decode
        cycle(1, LW_2_1, 32'h54, 0, 0, 5'd0, 32'h0,
              ev(6'h23, 5'd2, 1, 1, 0, 0, 32'd5, 32'd3, 32'd4, 1, 32'h54));
        cycle(1, ADD_3_2_1, 32'h58, 0, 1, 5'd2, 32'h77, enone(1, 1));
        cycle(1, ADD_3_2_1, 32'h58, 0, 0, 5'd0, 32'h0,
              ev(6'h00, 5'd3, 1, 0, 0, 0, 32'h77, 32'd5, 32'h0, 0, 32'h58));
        // lw followed by an unrelated sw: no stall
        cycle(1, LW_2_1, 32'h5C, 0, 0, 5'd0, 32'h0,
              ev(6'h23, 5'd2, 1, 1, 0, 0, 32'd5, 32'h77, 32'd4, 1, 32'h5C));
        cycle(1, SW_7_1, 32'h60, 0, 0, 5'd0, 32'h0,
              ev(6'h2B, 5'd0, 0, 0, 1, 0, 32'd5, 32'h0, 32'h0, 1, 32'h60));
        // flush over an instruction that would otherwise stall
        cycle(1, LW_2_1, 32'h64, 0, 0, 5'd0, 32'h0,
              ev(6'h23, 5'd2, 1, 1, 0, 0, 32'd5, 32'h77, 32'd4, 1, 32'h64));
        cycle(1, ADD_3_2_1, 32'h68, 1, 0, 5'd0, 32'h0, enone(0, 0));
        cycle(1, ILLEGAL, 32'h6C, 0, 0, 5'd0, 32'h0,
              ev(6'h3F, 5'd0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0, 1, 32'h6C));
        // reset asserted while a load-use stall is pending
        cycle(1, LW_2_1, 32'h70, 0, 0, 5'd0, 32'h0,
              ev(6'h23, 5'd2, 1, 1, 0, 0, 32'd5, 32'h77, 32'd4, 1, 32'h70));
        @(negedge clk);
        in_valid = 1'b1; in_instr = ADD_3_2_1; in_pc = 32'h74;
        #1;
        check("pre_rst_stall", 32'(stall), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_stall", 32'(stall), 32'd0);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_mem_read", 32'(out_mem_read), 32'd0);
        check("midrst_pc", out_pc, 32'd0);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        // register file was cleared by reset
        cycle(1, ADD_3_1_2, 32'h80, 0, 0, 5'd0, 32'h0,
              ev(6'h00, 5'd3, 1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 32'h80));
        cycle(0, 32'h0, 32'h0, 0, 0, 5'd0, 32'h0, enone(0, 1));

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
